// File: rtl/adder_scheduler_pkg.sv
// Shared definitions for the adder scheduler: slot length and FSM state encoding.
package adder_scheduler_pkg;

  // One operation occupies the shared adder for this many cycles, grant to grant.
  localparam int SLOT_LEN = 4;

  typedef enum logic [$clog2(SLOT_LEN)-1:0] {
    ST_ARB,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_CAPTURE
  } state_t;

endpackage

// File: rtl/adder_scheduler_rr_arbiter.sv
// Round-robin selector: picks the first active request at or after ptr, wrapping at NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] idx
);

  // Walk offsets from farthest to nearest so the closest request to ptr wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (req[(int'(ptr) + off) % NREQ]) begin
        grant                                 = '0;
        grant[(int'(ptr) + off) % NREQ]       = 1'b1;
        idx                                   = IDXW'((int'(ptr) + off) % NREQ);
      end
    end
  end

endmodule

// File: rtl/adder_scheduler.sv
// Time-multiplexes one two-cycle serial adder among NREQ requesters with a fixed
// four-cycle slot: grant, load a, load b, capture.
module adder_scheduler
  import adder_scheduler_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]      resp_data,
  output logic                  add_en,
  output logic [WIDTH-1:0]      add_x,
  input  logic [WIDTH-1:0]      add_out,
  output logic                  busy,
  output logic [31:0]           done_count
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state_reg;
  logic [IDXW-1:0]   ptr_reg;
  logic [IDXW-1:0]   idx_reg;
  logic [WIDTH-1:0]  b_reg;
  logic              add_en_reg;
  logic [WIDTH-1:0]  add_x_reg;
  logic [NREQ-1:0]   resp_valid_reg;
  logic [WIDTH-1:0]  resp_data_reg;
  logic [31:0]       done_count_reg;

  logic [NREQ-1:0]   grant;
  logic [IDXW-1:0]   grant_idx;
  logic [IDXW-1:0]   ptr_next;
  logic [WIDTH-1:0]  a_arr [NREQ];
  logic [WIDTH-1:0]  b_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
    assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign ptr_next = (grant_idx == IDXW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg      <= ST_ARB;
      ptr_reg        <= '0;
      idx_reg        <= '0;
      b_reg          <= '0;
      add_en_reg     <= 1'b0;
      add_x_reg      <= '0;
      resp_valid_reg <= '0;
      resp_data_reg  <= '0;
      done_count_reg <= '0;
    end else begin
      resp_valid_reg <= '0;
      resp_data_reg  <= '0;
      case (state_reg)
        ST_ARB: begin
          if (|req_valid) begin
            state_reg  <= ST_LOAD_A;
            ptr_reg    <= ptr_next;
            idx_reg    <= grant_idx;
            b_reg      <= b_arr[grant_idx];
            // Operand a goes straight into the adder drive register for LOAD_A.
            add_en_reg <= 1'b1;
            add_x_reg  <= a_arr[grant_idx];
          end else begin
            add_en_reg <= 1'b0;
            add_x_reg  <= '0;
          end
        end
        ST_LOAD_A: begin
          state_reg  <= ST_LOAD_B;
          add_en_reg <= 1'b1;
          add_x_reg  <= b_reg;
        end
        ST_LOAD_B: begin
          state_reg  <= ST_CAPTURE;
          add_en_reg <= 1'b0;
          add_x_reg  <= '0;
        end
        ST_CAPTURE: begin
          state_reg               <= ST_ARB;
          resp_valid_reg[idx_reg] <= 1'b1;
          resp_data_reg           <= add_out;
          done_count_reg          <= done_count_reg + 32'd1;
        end
        default: begin
          state_reg  <= ST_ARB;
          add_en_reg <= 1'b0;
          add_x_reg  <= '0;
        end
      endcase
    end
  end

  // Acceptance is the arbiter decision in the grant cycle itself, suppressed while in reset.
  assign req_ready  = (resetn && state_reg == ST_ARB) ? grant : '0;
  assign busy       = resetn && (state_reg != ST_ARB);
  assign resp_valid = resp_valid_reg;
  assign resp_data  = resp_data_reg;
  assign add_en     = add_en_reg;
  assign add_x      = add_x_reg;
  assign done_count = done_count_reg;

endmodule
